div_ratio_ctrl: RTL and testbench

//  Sequences divide-mode changes of the FMDLL clock divider (M select, clk2/clk4 outputs).

---
 rtl/div_ctrl_pkg.sv | 31 +++
 rtl/fb_edge_sync.sv | 30 +++
 rtl/div_ratio_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_div_ratio_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the FMDLL divide-ratio controller.
// State encoding, divider M encodings and the default cycle budgets.
package div_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_SWITCH  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } div_state_e;

    // M[1]=0 routes CLK_exit straight through, M[1]=1 selects the DIV_M path
    localparam logic [1:0] M_EXIT_0 = 2'd0;
    localparam logic [1:0] M_EXIT_1 = 2'd1;
    localparam logic [1:0] M_DIV_2  = 2'd2;
    localparam logic [1:0] M_DIV_3  = 2'd3;

    localparam logic [1:0] DEF_M           = M_EXIT_0;
    localparam int         DEF_HOLD_CYC    = 4;
    localparam int         DEF_SETTLE_CYC  = 4;
    localparam int         DEF_EDGE_CNT    = 3;
    localparam int         DEF_TIMEOUT_CYC = 64;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fb_edge_sync.sv
// Brings the divider's clk4 output into the clk_in domain and flags each
// rising edge with a one-cycle pulse (2-3 clk_in cycles after the edge).
module fb_edge_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clk4_fb,
    output logic fb_edge
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // NOTE: flops use non-blocking assignment so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= clk4_fb;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign fb_edge = sync2_q & ~dly_q;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Sequences FMDLL divider M changes: hold divider in reset, switch M, settle,
// release and confirm via clk4 feedback edges. Optional macro: DIV_CTRL_TIMEOUT_EN.
module div_ratio_ctrl
    import div_ctrl_pkg::*;
#(
    parameter logic [1:0] DEFAULT_M   = DEF_M,
    parameter int         HOLD_CYC    = DEF_HOLD_CYC,
    parameter int         SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int         EDGE_CNT    = DEF_EDGE_CNT,
    parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       cfg_req,
    input  logic [1:0] cfg_m,
    output logic       cfg_ack,
    output logic       cfg_busy,
    output logic [1:0] div_m_sel,
    output logic       div_rst_n,
    input  logic       clk4_fb,
    output logic       ready,
    output logic       err
);

    localparam int CNT_W  = $clog2(max3(HOLD_CYC, SETTLE_CYC, TIMEOUT_CYC) + 1);
    localparam int EDGE_W = $clog2(EDGE_CNT + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [EDGE_W-1:0] EDGE_TARGET = EDGE_W'(EDGE_CNT);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [EDGE_W-1:0] edge_q, edge_d, edge_inc;
    logic [1:0]        pend_m_q, pend_m_d;
    logic [1:0]        m_sel_q, m_sel_d;
    logic              div_rst_n_q, div_rst_n_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              boot_q, boot_d;
    logic              fb_edge;
    logic              timeout_hit;

    fb_edge_sync u_fb_edge_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .clk4_fb (clk4_fb),
        .fb_edge (fb_edge)
    );

`ifdef DIV_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic err_q;

    assign timeout_hit = (state_q == ST_RELEASE) && (cyc_q == TIMEOUT_LAST);

    // Only a RELEASE->IDLE transition is a timeout; it stays set until rst_n
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == ST_RELEASE && state_d == ST_IDLE) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        edge_inc = edge_q;
        if (fb_edge && edge_q != EDGE_TARGET) begin
            edge_inc = edge_q + EDGE_W'(1);
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d     = state_q;
        cyc_d       = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
        edge_d      = edge_q;
        pend_m_d    = pend_m_q;
        m_sel_d     = m_sel_q;
        div_rst_n_d = div_rst_n_q;
        ready_d     = ready_q;
        ack_d       = 1'b0;
        boot_d      = boot_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    if (cfg_m == m_sel_q && ready_q) begin
                        state_d = ST_DONE;
                    end else begin
                        pend_m_d    = cfg_m;
                        ready_d     = 1'b0;
                        div_rst_n_d = 1'b0;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                div_rst_n_d = 1'b0;
                if (cyc_q == HOLD_LAST) begin
                    m_sel_d = pend_m_q;
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (cyc_q == SETTLE_LAST) begin
                    div_rst_n_d = 1'b1;
                    edge_d      = '0;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                edge_d = edge_inc;
                if (edge_inc == EDGE_TARGET) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    // Divider left running; a fresh request retries from HOLD
                    boot_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                boot_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cyc_d = '0;
        end

        // Boot completion raises ready but is not an answer to any request
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            ready_d = 1'b1;
            ack_d   = ~boot_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cyc_q       <= '0;
            edge_q      <= '0;
            pend_m_q    <= DEFAULT_M;
            m_sel_q     <= DEFAULT_M;
            div_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b1;
            boot_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            edge_q      <= edge_d;
            pend_m_q    <= pend_m_d;
            m_sel_q     <= m_sel_d;
            div_rst_n_q <= div_rst_n_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            boot_q      <= boot_d;
        end
    end

    assign div_m_sel = m_sel_q;
    assign div_rst_n = div_rst_n_q;
    assign ready     = ready_q;
    assign cfg_ack   = ack_q;
    assign cfg_busy  = busy_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Scoreboard bench for div_ratio_ctrl: random and directed M-change requests
// checked against a request-level model of applied M and readiness.
module tb_div_ratio_ctrl;

    localparam logic [1:0] DEFAULT_M   = 2'd0;
    localparam int         HOLD_CYC    = 4;
    localparam int         SETTLE_CYC  = 4;
    localparam int         EDGE_CNT    = 3;
    localparam int         TIMEOUT_CYC = 64;
    localparam int         WAIT_BOUND  = 400;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_req = 1'b0;
    logic [1:0] cfg_m = 2'd0;
    logic       clk4_fb = 1'b0;
    logic       cfg_ack, cfg_busy, div_rst_n, ready, err;
    logic [1:0] div_m_sel;

    typedef struct {
        logic [1:0] m;
        bit         fast;
        int         issue_cyc;
        int         pulses;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         low_run = 0;
    bit         fb_en = 1'b0;
    bit         prev_ack = 1'b0;
    logic [1:0] model_m = DEFAULT_M;
    bit         model_ready = 1'b0;

    div_ratio_ctrl #(
        .DEFAULT_M   (DEFAULT_M),
        .HOLD_CYC    (HOLD_CYC),
        .SETTLE_CYC  (SETTLE_CYC),
        .EDGE_CNT    (EDGE_CNT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cfg_req   (cfg_req),
        .cfg_m     (cfg_m),
        .cfg_ack   (cfg_ack),
        .cfg_busy  (cfg_busy),
        .div_m_sel (div_m_sel),
        .div_rst_n (div_rst_n),
        .clk4_fb   (clk4_fb),
        .ready     (ready),
        .err       (err)
    );

    initial forever #5 clk_in = ~clk_in;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // clk4 feedback: toggles every 4 clk_in cycles, offset from the clk_in edge
    initial forever begin
        repeat (4) @(posedge clk_in);
        #3;
        if (fb_en) clk4_fb = ~clk4_fb;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: measures divider reset pulses and pops the scoreboard on each ack
    initial forever begin
        exp_t e;
        @(negedge clk_in);
        if (!rst_n) begin
            low_run  = 0;
            prev_ack = 1'b0;
        end else begin
            if (div_rst_n === 1'b0) begin
                low_run++;
                check("ready_low_while_div_reset", ready, 0);
            end else if (low_run > 0) begin
                check("div_rst_low_length", low_run, HOLD_CYC + SETTLE_CYC);
                low_run = 0;
                pulses++;
            end
            if (cfg_ack === 1'b1) begin
                if (prev_ack) fail_now("ack_width", "cfg_ack high for 2 cycles, required 1");
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_ack", "cfg_ack pulsed with no request outstanding, required none");
                end else begin
                    e = sb_q.pop_front();
                    check("ack_div_m_sel", div_m_sel, e.m);
                    check("ack_ready", ready, 1);
                    check("ack_reset_pulses", pulses, e.pulses + (e.fast ? 0 : 1));
                    if (e.fast) check("fast_ack_latency", cyc - e.issue_cyc, 1);
                    else check("full_ack_latency_min", (cyc - e.issue_cyc) > (HOLD_CYC + SETTLE_CYC + 1), 1);
                end
            end
            prev_ack = (cfg_ack === 1'b1);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_in);
        while (cfg_busy !== 1'b0 && n < WAIT_BOUND) begin
            @(negedge clk_in);
            n++;
        end
        if (cfg_busy !== 1'b0) fail_now("idle_timeout", "cfg_busy still high after wait bound, required 0");
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk_in);
        while (ready !== 1'b1 && n < WAIT_BOUND) begin
            @(negedge clk_in);
            n++;
        end
        if (ready !== 1'b1) fail_now("ready_timeout", "ready still low after wait bound, required 1");
    endtask

    // One request from IDLE; model decides fast (already applied) or full path
    task automatic issue(input logic [1:0] m, input bit expect_ack, input bit hold, output bit fast);
        exp_t e;
        wait_idle();
        @(posedge clk_in);
        #2;
        cfg_m   = m;
        cfg_req = 1'b1;
        e.m         = m;
        e.fast      = (m == model_m) && model_ready;
        e.issue_cyc = cyc;
        e.pulses    = pulses;
        fast        = e.fast;
        if (expect_ack) sb_q.push_back(e);
        if (!e.fast) begin
            model_m     = m;
            model_ready = expect_ack;
        end
        @(posedge clk_in);
        #2;
        if (!hold) cfg_req = 1'b0;
        @(negedge clk_in);
        check("busy_after_req", cfg_busy, 1);
    endtask

    // Request with a different M while the sequence is running; must be ignored
    task automatic inject_ignored();
        repeat (3) @(posedge clk_in);
        #2;
        cfg_m   = model_m ^ 2'(1 + $urandom_range(2));
        cfg_req = 1'b1;
        repeat (2) @(posedge clk_in);
        #2;
        cfg_req = 1'b0;
    endtask

    initial begin
        bit         f;
        logic [1:0] m;
        exp_t       e2;
        int         n;

        fb_en = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        check("rst_div_m_sel", div_m_sel, DEFAULT_M);
        check("rst_div_rst_n", div_rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_cfg_ack", cfg_ack, 0);
        check("rst_cfg_busy", cfg_busy, 1);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // Boot: ready rises, no ack (monitor flags any ack with empty queue)
        wait_ready();
        model_m     = DEFAULT_M;
        model_ready = 1'b1;
        check("boot_div_rst_n", div_rst_n, 1);
        check("boot_div_m_sel", div_m_sel, DEFAULT_M);
        check("boot_pulses", pulses, 1);

        // Full change to M=2 with an ignored request while busy
        issue(2'd2, 1'b1, 1'b0, f);
        inject_ignored();
        wait_idle();
        check("change_m2_div_m_sel", div_m_sel, 2);

        // Same M while ready: fast ack, no divider reset
        issue(2'd2, 1'b1, 1'b0, f);
        wait_idle();
        check("fast_div_rst_n", div_rst_n, 1);

        // cfg_req held through the ack re-evaluates in IDLE: one extra fast ack
        issue(2'd1, 1'b1, 1'b1, f);
        n = 0;
        while (cfg_ack !== 1'b1 && n < WAIT_BOUND) begin
            @(negedge clk_in);
            n++;
        end
        if (cfg_ack !== 1'b1) fail_now("held_ack_timeout", "no ack for held request, required one");
        @(posedge clk_in);
        #2;
        e2.m         = 2'd1;
        e2.fast      = 1'b1;
        e2.issue_cyc = cyc;
        e2.pulses    = pulses;
        sb_q.push_back(e2);
        @(posedge clk_in);
        #2;
        cfg_req = 1'b0;
        wait_idle();
        check("held_div_m_sel", div_m_sel, 1);

        // Random requests, some with ignored mid-sequence requests
        for (int i = 0; i < 24; i++) begin
            m = 2'($urandom_range(3));
            issue(m, 1'b1, 1'b0, f);
            if (!f && $urandom_range(1) == 1) inject_ignored();
            wait_idle();
            check("rand_div_m_sel", div_m_sel, model_m);
        end

        // Feedback stuck: no confirming edges
        fb_en = 1'b0;
        repeat (10) @(posedge clk_in);
        m = model_m + 2'd1;
`ifdef DIV_CTRL_TIMEOUT_EN
        issue(m, 1'b0, 1'b0, f);
        wait_idle();
        check("timeout_err", err, 1);
        check("timeout_ready", ready, 0);
        check("timeout_div_rst_n", div_rst_n, 1);
        check("timeout_div_m_sel", div_m_sel, m);
        fb_en = 1'b1;
        repeat (10) @(posedge clk_in);
        issue(m, 1'b1, 1'b0, f);
        wait_idle();
        check("retry_ready", ready, 1);
        check("retry_err_sticky", err, 1);
`else
        issue(m, 1'b1, 1'b0, f);
        repeat (150) @(negedge clk_in);
        check("stuck_busy", cfg_busy, 1);
        check("stuck_ready", ready, 0);
        check("stuck_div_rst_n", div_rst_n, 1);
        check("stuck_err", err, 0);
        fb_en = 1'b1;
        wait_idle();
        check("stuck_recover_ready", ready, 1);
`endif

        // rst_n pulsed mid-SWITCH restarts boot with DEFAULT_M
        m = model_m ^ 2'd2;
        issue(m, 1'b1, 1'b0, f);
        repeat (HOLD_CYC + 1) @(posedge clk_in);
        #2;
        check("switch_div_m_sel", div_m_sel, m);
        check("switch_div_rst_n", div_rst_n, 0);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_div_m_sel", div_m_sel, DEFAULT_M);
        check("midrst_div_rst_n", div_rst_n, 0);
        check("midrst_busy", cfg_busy, 1);
        check("midrst_err", err, 0);
        repeat (3) @(posedge clk_in);
        #2;
        rst_n       = 1'b1;
        model_m     = DEFAULT_M;
        model_ready = 1'b0;
        wait_ready();
        model_ready = 1'b1;
        wait_idle();
        check("reboot_div_m_sel", div_m_sel, DEFAULT_M);
        issue(2'd3, 1'b1, 1'b0, f);
        wait_idle();
        check("post_reboot_div_m_sel", div_m_sel, 3);

        repeat (5) @(negedge clk_in);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
